calc_window_stats: RTL and testbench
====================================

Name: calc_window_stats

Overview:
- Streaming window-statistics engine for the stereo distance pipeline.
- Takes paired left/right pixels (f, g) one sample per handshake and keeps a sliding window of WIN samples per row.
- Once the window is full, emits running sums per window position: Σf, Σf², Σg, Σg², Σfg, plus position (x, y).
- Downstream correlation/distance logic consumes these sums; replaces the fixed 16-tap, 3-bit, f-only statistics stage.

Parameters:
- PIX_W, 3, pixel width in bits (unsigned).
- LOG_WIN, 4, log2 of window length; WIN = 2**LOG_WIN.
- LINE_LEN, 94, samples per row; must be ≥ WIN.
- ROWS, 16, rows per frame.

Ports:
- clk  in  1  clock; all flops on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; arms a frame when in IDLE, ignored otherwise.
- in_valid  in  1  f_in/g_in valid.
- in_ready  out  1  block accepts a sample this cycle.
- f_in  in  PIX_W  left pixel.
- g_in  in  PIX_W  right pixel.
- out_valid  out  1  statistics valid.
- out_ready  in  1  downstream accepts statistics.
- sum_f  out  PIX_W+LOG_WIN  Σf over window.
- sum_g  out  PIX_W+LOG_WIN  Σg over window.
- sum_f2  out  2*PIX_W+LOG_WIN  Σf².
- sum_g2  out  2*PIX_W+LOG_WIN  Σg².
- sum_fg  out  2*PIX_W+LOG_WIN  Σf·g.
- out_x  out  clog2(LINE_LEN)  window position in row: 0 .. LINE_LEN-WIN.
- out_y  out  clog2(ROWS)  row index.
- frame_done  out  1  one-cycle pulse after the last output of the frame is accepted.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; all outputs 0 (in_ready=0, out_valid=0, frame_done=0).
  - Sums, counters and window shift registers cleared.
  - Reset mid-frame abandons the frame; nothing further is emitted until the next start.
- Accept condition: accept = in_valid & in_ready.
- in_ready = (state FILL or RUN) & (!out_valid | out_ready). Single-register output stage, no skid.
- FSM:
  - IDLE: start → FILL; y=0, col=0.
  - FILL: on accept, push sample, accumulate (add only), col++. When col reaches WIN-1 on an accept → RUN. No output in FILL.
  - RUN: on accept, add new sample terms and subtract terms of sample leaving the window (shifted out, WIN deep).
    - Output register loads updated sums, out_x = col-(WIN-1), out_y = y; out_valid=1 next cycle (latency 1 from accept).
    - On the accept with col = LINE_LEN-1:
      - If y < ROWS-1: y++, col=0, window and accumulators cleared → FILL.
      - If y = ROWS-1: → DRAIN.
  - DRAIN: wait until the held output is accepted (out_valid & out_ready) → DONE.
  - DONE: frame_done=1 for one cycle → IDLE.
- out_valid clears on out_ready when no new sample is loaded the same cycle. Outputs hold stable while out_valid & !out_ready.
- Simultaneous output-accept and new-sample-accept in RUN: new output loads, out_valid stays 1.
- Arithmetic:
  - All values unsigned. Products are 2*PIX_W bits.
  - Accumulator widths are sized for WIN·max exactly, so no overflow or wrap.
  - Subtraction never goes negative: window-invariant.
- Row clear takes effect on the same edge as the last accept of the row. First sample of the next row is accepted the following cycle if in_valid.
- start during FILL/RUN/DRAIN/DONE is ignored.

Optional Feature:
- Macro CALC_SAD_EN.
  - Defined: adds output port sad (PIX_W+LOG_WIN bits) = Σ|f-g| over the window, maintained by the same add/subtract scheme and loaded and held with the other sums. Reset value 0.
  - Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Constant f=g=5, PIX_W=3, LOG_WIN=4, LINE_LEN=94, ROWS=1 → exactly 79 outputs, out_x 0..78, each with sum_f=sum_g=80 and sum_f2=sum_g2=sum_fg=400; then frame_done pulses once.
- Ramp f=x mod 8, g=0 → out_x=0: sum_f=56, sum_f2=280, sum_g=sum_fg=0; out_x=1: sum_f=56; every output in the row equals 56/280.
- Max values f=g=7 → sum_f=112, sum_f2=sum_fg=784, with no overflow at any position.
- out_ready held low 5 cycles mid-row → in_ready=0 throughout, outputs stable, no sample lost; the next output matches the golden model.
- rst_n pulsed low mid row 3 → all outputs 0 immediately. A new start with a 2-row frame yields 2×79 outputs with out_y 0,1 and correct sums; the row-1 first output reflects only row-1 data.
- With CALC_SAD_EN: f=6, g=2 constant → sad=64 on all outputs; f=g → sad=0.

Source files
------------

// File: rtl/calc_window_stats_if.sv
// calc_window_stats_if
//   Sample-in / statistics-out bundle for calc_window_stats.
//   slave  modport : the statistics engine (drives in_ready and all results).
//   master modport : the producer/consumer side (drives start, samples, out_ready).
//   Signals: start, in_valid/in_ready/f_in/g_in (sample stream),
//            out_valid/out_ready/sum_f/sum_g/sum_f2/sum_g2/sum_fg/out_x/out_y
//            (statistics stream), frame_done, and sad when CALC_SAD_EN is defined.
// Optional feature macro: CALC_SAD_EN (adds the sad result).
interface calc_window_stats_if #(
  parameter int PIX_W    = 3,
  parameter int LOG_WIN  = 4,
  parameter int LINE_LEN = 94,
  parameter int ROWS     = 16
);
  localparam int S_W = PIX_W + LOG_WIN;
  localparam int Q_W = 2 * PIX_W + LOG_WIN;
  localparam int X_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int Y_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] f_in;
  logic [PIX_W-1:0] g_in;
  logic             out_valid;
  logic             out_ready;
  logic [S_W-1:0]   sum_f;
  logic [S_W-1:0]   sum_g;
  logic [Q_W-1:0]   sum_f2;
  logic [Q_W-1:0]   sum_g2;
  logic [Q_W-1:0]   sum_fg;
  logic [X_W-1:0]   out_x;
  logic [Y_W-1:0]   out_y;
  logic             frame_done;
`ifdef CALC_SAD_EN
  logic [S_W-1:0]   sad;
`endif

  modport master (
    output start, in_valid, f_in, g_in, out_ready,
    input  in_ready, out_valid, sum_f, sum_g, sum_f2, sum_g2, sum_fg,
           out_x, out_y, frame_done
`ifdef CALC_SAD_EN
         , sad
`endif
  );

  modport slave (
    input  start, in_valid, f_in, g_in, out_ready,
    output in_ready, out_valid, sum_f, sum_g, sum_f2, sum_g2, sum_fg,
           out_x, out_y, frame_done
`ifdef CALC_SAD_EN
         , sad
`endif
  );
endinterface

// File: rtl/calc_window_stats.sv
// calc_window_stats
//   Streaming sliding-window statistics over paired pixels (f, g). Keeps the
//   last WIN = 2**LOG_WIN samples of the current row and, once the window is
//   full, emits sum f, sum g, sum f^2, sum g^2, sum f*g and the window position
//   (out_x, out_y) for every accepted sample. Single output register, no skid.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : calc_window_stats_if.slave (sample stream in, statistics out,
//           start / frame_done control)
// Optional feature macro: CALC_SAD_EN -- adds bus.sad = sum |f-g| over the window.
module calc_window_stats #(
  parameter int PIX_W    = 3,
  parameter int LOG_WIN  = 4,
  parameter int LINE_LEN = 94,
  parameter int ROWS     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  calc_window_stats_if.slave bus
);
  localparam int WIN = 1 << LOG_WIN;
  localparam int P_W = 2 * PIX_W;
  localparam int S_W = PIX_W + LOG_WIN;
  localparam int Q_W = 2 * PIX_W + LOG_WIN;
  localparam int X_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int Y_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [X_W-1:0] COL_LAST     = X_W'(LINE_LEN - 1);
  localparam logic [X_W-1:0] COL_FILL_END = X_W'(WIN - 2);
  localparam logic [X_W-1:0] X_OFF        = X_W'(WIN - 1);
  localparam logic [Y_W-1:0] ROW_LAST     = Y_W'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic logic [P_W-1:0] mul_px(input logic [PIX_W-1:0] a,
                                            input logic [PIX_W-1:0] b);
    return P_W'(a) * P_W'(b);
  endfunction

`ifdef CALC_SAD_EN
  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction
`endif

  state_t           state_q, state_d;
  logic [X_W-1:0]   col_q, col_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [PIX_W-1:0] win_f_q [WIN];
  logic [PIX_W-1:0] win_f_d [WIN];
  logic [PIX_W-1:0] win_g_q [WIN];
  logic [PIX_W-1:0] win_g_d [WIN];
  logic [PIX_W-1:0] shift_f_s [WIN];
  logic [PIX_W-1:0] shift_g_s [WIN];
  logic [PIX_W-1:0] old_f_s, old_g_s;
  logic [S_W-1:0]   acc_f_q, acc_f_d, acc_g_q, acc_g_d, nxt_f_s, nxt_g_s;
  logic [Q_W-1:0]   acc_f2_q, acc_f2_d, acc_g2_q, acc_g2_d, acc_fg_q, acc_fg_d;
  logic [Q_W-1:0]   nxt_f2_s, nxt_g2_s, nxt_fg_s;
  logic [S_W-1:0]   sf_q, sf_d, sg_q, sg_d;
  logic [Q_W-1:0]   sf2_q, sf2_d, sg2_q, sg2_d, sfg_q, sfg_d;
  logic [X_W-1:0]   ox_q, ox_d;
  logic [Y_W-1:0]   oy_q, oy_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             in_rdy_s, in_acc_s, out_acc_s;
`ifdef CALC_SAD_EN
  logic [S_W-1:0]   acc_sad_q, acc_sad_d, nxt_sad_s, sad_q, sad_d;
`endif

  // Handshake qualifiers: a sample is taken only when the output slot is free or draining.
  always_comb begin
    in_rdy_s  = ((state_q == FILL) || (state_q == RUN)) && (!out_valid_q || bus.out_ready);
    in_acc_s  = bus.in_valid && in_rdy_s;
    out_acc_s = out_valid_q && bus.out_ready;
  end

  // Window shifted by one sample and sums updated with entering/leaving terms.
  always_comb begin
    old_f_s      = win_f_q[WIN-1];
    old_g_s      = win_g_q[WIN-1];
    shift_f_s[0] = bus.f_in;
    shift_g_s[0] = bus.g_in;
    for (int i = 1; i < WIN; i++) begin
      shift_f_s[i] = win_f_q[i-1];
      shift_g_s[i] = win_g_q[i-1];
    end
    // The leaving slot is zero until the window has filled, so the same
    // add/subtract serves FILL. Add-then-subtract may wrap transiently; the
    // modular result is exact because the true sum always fits.
    nxt_f_s  = acc_f_q + S_W'(bus.f_in) - S_W'(old_f_s);
    nxt_g_s  = acc_g_q + S_W'(bus.g_in) - S_W'(old_g_s);
    nxt_f2_s = acc_f2_q + Q_W'(mul_px(bus.f_in, bus.f_in)) - Q_W'(mul_px(old_f_s, old_f_s));
    nxt_g2_s = acc_g2_q + Q_W'(mul_px(bus.g_in, bus.g_in)) - Q_W'(mul_px(old_g_s, old_g_s));
    nxt_fg_s = acc_fg_q + Q_W'(mul_px(bus.f_in, bus.g_in)) - Q_W'(mul_px(old_f_s, old_g_s));
`ifdef CALC_SAD_EN
    nxt_sad_s = acc_sad_q + S_W'(abs_diff(bus.f_in, bus.g_in)) - S_W'(abs_diff(old_f_s, old_g_s));
`endif
  end

  // Frame sequencing, window/accumulator update and output-register load.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    y_d         = y_q;
    win_f_d     = win_f_q;
    win_g_d     = win_g_q;
    acc_f_d     = acc_f_q;
    acc_g_d     = acc_g_q;
    acc_f2_d    = acc_f2_q;
    acc_g2_d    = acc_g2_q;
    acc_fg_d    = acc_fg_q;
    sf_d        = sf_q;
    sg_d        = sg_q;
    sf2_d       = sf2_q;
    sg2_d       = sg2_q;
    sfg_d       = sfg_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    out_valid_d = out_acc_s ? 1'b0 : out_valid_q;
`ifdef CALC_SAD_EN
    acc_sad_d   = acc_sad_q;
    sad_d       = sad_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = FILL;
          col_d    = '0;
          y_d      = '0;
          win_f_d  = '{default: '0};
          win_g_d  = '{default: '0};
          acc_f_d  = '0;
          acc_g_d  = '0;
          acc_f2_d = '0;
          acc_g2_d = '0;
          acc_fg_d = '0;
`ifdef CALC_SAD_EN
          acc_sad_d = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        if (in_acc_s) begin
          win_f_d  = shift_f_s;
          win_g_d  = shift_g_s;
          acc_f_d  = nxt_f_s;
          acc_g_d  = nxt_g_s;
          acc_f2_d = nxt_f2_s;
          acc_g2_d = nxt_g2_s;
          acc_fg_d = nxt_fg_s;
`ifdef CALC_SAD_EN
          acc_sad_d = nxt_sad_s;
`endif
          col_d    = col_q + X_W'(1'b1);
          state_d  = (col_q == COL_FILL_END) ? RUN : FILL;
        end else begin
          state_d = FILL;
        end
      end
      RUN: begin
        if (in_acc_s) begin
          win_f_d     = shift_f_s;
          win_g_d     = shift_g_s;
          acc_f_d     = nxt_f_s;
          acc_g_d     = nxt_g_s;
          acc_f2_d    = nxt_f2_s;
          acc_g2_d    = nxt_g2_s;
          acc_fg_d    = nxt_fg_s;
          sf_d        = nxt_f_s;
          sg_d        = nxt_g_s;
          sf2_d       = nxt_f2_s;
          sg2_d       = nxt_g2_s;
          sfg_d       = nxt_fg_s;
          ox_d        = col_q - X_OFF;
          oy_d        = y_q;
          out_valid_d = 1'b1;
`ifdef CALC_SAD_EN
          acc_sad_d   = nxt_sad_s;
          sad_d       = nxt_sad_s;
`endif
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (y_q == ROW_LAST) begin
              state_d = DRAIN;
            end else begin
              // Next row starts from an empty window on this same edge.
              state_d  = FILL;
              y_d      = y_q + Y_W'(1'b1);
              win_f_d  = '{default: '0};
              win_g_d  = '{default: '0};
              acc_f_d  = '0;
              acc_g_d  = '0;
              acc_f2_d = '0;
              acc_g2_d = '0;
              acc_fg_d = '0;
`ifdef CALC_SAD_EN
              acc_sad_d = '0;
`endif
            end
          end else begin
            col_d   = col_q + X_W'(1'b1);
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        state_d = out_acc_s ? DONE : DRAIN;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    frame_done_d = (state_d == DONE);
  end

  // State, window, accumulators and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      y_q          <= '0;
      win_f_q      <= '{default: '0};
      win_g_q      <= '{default: '0};
      acc_f_q      <= '0;
      acc_g_q      <= '0;
      acc_f2_q     <= '0;
      acc_g2_q     <= '0;
      acc_fg_q     <= '0;
      sf_q         <= '0;
      sg_q         <= '0;
      sf2_q        <= '0;
      sg2_q        <= '0;
      sfg_q        <= '0;
      ox_q         <= '0;
      oy_q         <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef CALC_SAD_EN
      acc_sad_q    <= '0;
      sad_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      y_q          <= y_d;
      win_f_q      <= win_f_d;
      win_g_q      <= win_g_d;
      acc_f_q      <= acc_f_d;
      acc_g_q      <= acc_g_d;
      acc_f2_q     <= acc_f2_d;
      acc_g2_q     <= acc_g2_d;
      acc_fg_q     <= acc_fg_d;
      sf_q         <= sf_d;
      sg_q         <= sg_d;
      sf2_q        <= sf2_d;
      sg2_q        <= sg2_d;
      sfg_q        <= sfg_d;
      ox_q         <= ox_d;
      oy_q         <= oy_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
`ifdef CALC_SAD_EN
      acc_sad_q    <= acc_sad_d;
      sad_q        <= sad_d;
`endif
    end
  end

  assign bus.in_ready   = in_rdy_s;
  assign bus.out_valid  = out_valid_q;
  assign bus.sum_f      = sf_q;
  assign bus.sum_g      = sg_q;
  assign bus.sum_f2     = sf2_q;
  assign bus.sum_g2     = sg2_q;
  assign bus.sum_fg     = sfg_q;
  assign bus.out_x      = ox_q;
  assign bus.out_y      = oy_q;
  assign bus.frame_done = frame_done_q;
`ifdef CALC_SAD_EN
  assign bus.sad        = sad_q;
`endif
endmodule

// File: tb/tb_calc_window_stats.sv
// tb_calc_window_stats
//   Directed frame sequence with randomized pixels and handshakes, checked
//   against a window-sum reference model computed straight from the row data.
module tb_calc_window_stats;
  localparam int PW  = 3;
  localparam int LW  = 4;
  localparam int LL  = 94;
  localparam int RW  = 4;
  localparam int WIN = 1 << LW;

  typedef struct {
    int sf, sg, sf2, sg2, sfg, sad, x, y;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  calc_window_stats_if #(.PIX_W(PW), .LOG_WIN(LW), .LINE_LEN(LL), .ROWS(RW)) bus ();

  calc_window_stats #(.PIX_W(PW), .LOG_WIN(LW), .LINE_LEN(LL), .ROWS(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_pass = 0;
  int   n_fail = 0;
  int   n_tot  = 0;
  int   n_out  = 0;
  int   cur_mode = 0;
  exp_t exp_q[$];
  int   row_f[LL];
  int   row_g[LL];
  int   m_col = 0;
  int   m_row = 0;
  bit   m_active = 1'b0;
  bit   m_ov = 1'b0;
  bit   m_done = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tot++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_ov     = 1'b0;
    m_done   = 1'b0;
    m_col    = 0;
    m_row    = 0;
    exp_q.delete();
  endtask

  // Records an accepted sample; produces the expected window sums once WIN samples exist.
  task automatic model_push(input bit [2:0] f, input bit [2:0] g, output bit prod);
    exp_t e;
    row_f[m_col] = int'(f);
    row_g[m_col] = int'(g);
    prod = 1'b0;
    if (m_col >= WIN - 1) begin
      e = '{default: 0};
      for (int k = m_col - WIN + 1; k <= m_col; k++) begin
        e.sf  += row_f[k];
        e.sg  += row_g[k];
        e.sf2 += row_f[k] * row_f[k];
        e.sg2 += row_g[k] * row_g[k];
        e.sfg += row_f[k] * row_g[k];
        e.sad += (row_f[k] > row_g[k]) ? row_f[k] - row_g[k] : row_g[k] - row_f[k];
      end
      e.x = m_col - (WIN - 1);
      e.y = m_row;
      exp_q.push_back(e);
      prod = 1'b1;
    end
    m_col++;
    if (m_col == LL) begin
      m_col = 0;
      if (m_row == RW - 1) m_active = 1'b0;
      else m_row++;
    end
  endtask

  task automatic pix(input int mode, output bit [2:0] f, output bit [2:0] g);
    case (mode)
      1: begin f = 3'd5; g = 3'd5; end
      2: begin f = 3'(m_col % 8); g = 3'd0; end
      3: begin f = 3'd7; g = 3'd7; end
      4: begin f = 3'd6; g = 3'd2; end
      default: begin f = 3'($urandom_range(7)); g = 3'($urandom_range(7)); end
    endcase
  endtask

  // One clock: drive at the falling edge, check just after, advance to the next falling edge.
  task automatic cyc(input bit v, input bit [2:0] f, input bit [2:0] g, input bit ordy, input bit st);
    bit   ai, ao, prod, was_active, idle;
    exp_t e;
    bus.in_valid  = v;
    bus.f_in      = f;
    bus.g_in      = g;
    bus.out_ready = ordy;
    bus.start     = st;
    #1;
    check("in_ready",   bus.in_ready,   m_active && (!m_ov || ordy));
    check("out_valid",  bus.out_valid,  m_ov);
    check("frame_done", bus.frame_done, m_done);
    if (m_ov && exp_q.size() > 0) begin
      e = exp_q[0];
      check("sum_f",  bus.sum_f,  e.sf);
      check("sum_g",  bus.sum_g,  e.sg);
      check("sum_f2", bus.sum_f2, e.sf2);
      check("sum_g2", bus.sum_g2, e.sg2);
      check("sum_fg", bus.sum_fg, e.sfg);
      check("out_x",  bus.out_x,  e.x);
      check("out_y",  bus.out_y,  e.y);
`ifdef CALC_SAD_EN
      check("sad", bus.sad, e.sad);
      if (cur_mode == 1) check("const5_sad", bus.sad, 0);
      if (cur_mode == 4) check("f6g2_sad", bus.sad, 64);
`endif
      if (cur_mode == 1) begin
        check("const5_sum_f", bus.sum_f, 80);
        check("const5_sum_fg", bus.sum_fg, 400);
      end
      if (cur_mode == 2) begin
        check("ramp_sum_f", bus.sum_f, 56);
        check("ramp_sum_f2", bus.sum_f2, 280);
        check("ramp_sum_fg", bus.sum_fg, 0);
      end
      if (cur_mode == 3) begin
        check("max_sum_f", bus.sum_f, 112);
        check("max_sum_fg", bus.sum_fg, 784);
      end
    end
    if (bus.out_valid && ordy) n_out++;
    idle       = !m_active && !m_ov && !m_done;
    ai         = v && m_active && (!m_ov || ordy);
    ao         = m_ov && ordy;
    was_active = m_active;
    if (ao) void'(exp_q.pop_front());
    prod = 1'b0;
    if (ai) model_push(f, g, prod);
    m_ov   = prod ? 1'b1 : (ao ? 1'b0 : m_ov);
    m_done = ao && !was_active && (exp_q.size() == 0);
    if (st && idle) begin
      m_active = 1'b1;
      m_row    = 0;
      m_col    = 0;
    end
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_in_ready"},   bus.in_ready,   0);
    check({tag, "_out_valid"},  bus.out_valid,  0);
    check({tag, "_frame_done"}, bus.frame_done, 0);
    check({tag, "_sum_f"},      bus.sum_f,      0);
    check({tag, "_sum_g"},      bus.sum_g,      0);
    check({tag, "_sum_f2"},     bus.sum_f2,     0);
    check({tag, "_sum_g2"},     bus.sum_g2,     0);
    check({tag, "_sum_fg"},     bus.sum_fg,     0);
    check({tag, "_out_x"},      bus.out_x,      0);
    check({tag, "_out_y"},      bus.out_y,      0);
`ifdef CALC_SAD_EN
    check({tag, "_sad"},        bus.sad,        0);
`endif
  endtask

  task automatic run_frame(input int mode, input int pv, input int pr, input int stall_row);
    int     c;
    bit     stalled, v, r, st;
    bit [2:0] f, g;
    cur_mode = mode;
    n_out    = 0;
    stalled  = 1'b0;
    cyc(1'b0, 3'd0, 3'd0, 1'b1, 1'b1);
    c = 0;
    while (!m_done && c < 5000) begin
      pix(mode, f, g);
      if (stall_row >= 0 && !stalled && m_row == stall_row && m_col == 50) begin
        stalled = 1'b1;
        repeat (5) cyc(1'b1, f, g, 1'b0, 1'b0);
      end
      v  = ($urandom_range(99) < pv);
      r  = ($urandom_range(99) < pr);
      st = (mode == 0) && ($urandom_range(40) == 0);
      cyc(v, f, g, r, st);
      c++;
    end
    check("frame_within_budget", m_done, 1);
    cyc(1'b0, 3'd0, 3'd0, 1'b1, 1'b0);
    cyc(1'b0, 3'd0, 3'd0, 1'b1, 1'b0);
    check("outputs_per_frame", n_out, RW * (LL - WIN + 1));
  endtask

  initial begin
    int c;
    bit v, r;
    bit [2:0] f, g;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.f_in      = 3'd0;
    bus.g_in      = 3'd0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_frame(1, 100, 100, -1);   // constant 5
    run_frame(2, 100, 100, 1);    // ramp with 5-cycle output stall mid row 1
    run_frame(3, 80, 90, -1);     // full-scale pixels
    run_frame(4, 90, 80, -1);     // f=6, g=2
    run_frame(0, 70, 70, -1);     // random data and handshakes

    // Abandon a frame with reset in the middle of row 3.
    cur_mode = 0;
    cyc(1'b0, 3'd0, 3'd0, 1'b1, 1'b1);
    c = 0;
    while (!(m_row == 3 && m_col >= 40) && c < 3000) begin
      pix(0, f, g);
      v = ($urandom_range(99) < 85);
      r = ($urandom_range(99) < 85);
      cyc(v, f, g, r, 1'b0);
      c++;
    end
    check("reach_row3_within_budget", (c < 3000), 1);
    rst_n = 1'b0;
    #1;
    check_zero("midframe_reset");
    model_reset();
    #2 rst_n = 1'b1;
    @(negedge clk);
    repeat (6) cyc(1'b1, 3'd3, 3'd4, 1'b1, 1'b0);

    run_frame(0, 85, 85, -1);     // fresh frame after the abandoned one

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
